byte_ram: RTL and testbench

//  Byte-addressable 512x8 data memory for the basic RISC data path; serves byte,

---
 rtl/byte_ram.sv | 67 ++++++
 tb/tb_byte_ram.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_ram.sv
// byte_ram: 512x8 big-endian byte-addressable data memory with byte/half/word
// loads and stores, one access per enable request, completion flagged on mfc.
module byte_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [DATA_W-1:0] data_out,
  output logic              mfc,
  input  logic              enable,
  input  logic              read_write,
  input  logic              sig,
  input  logic [1:0]        data_length,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in
);
  typedef enum logic {IDLE, DONE} state_t;
  state_t r_state, w_next;
  logic [7:0] memory [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_data, w_rdata;
  logic [ADDR_W-1:0] w_a1, w_a2, w_a3;
  logic [7:0] w_b0, w_b1, w_b2, w_b3;
  logic w_accept;
  assign w_a1 = address + ADDR_W'(1);
  assign w_a2 = address + ADDR_W'(2);
  assign w_a3 = address + ADDR_W'(3);
  assign w_b0 = memory[address];
  assign w_b1 = memory[w_a1];
  assign w_b2 = memory[w_a2];
  assign w_b3 = memory[w_a3];
  assign w_accept = reset_n && r_state == IDLE && enable;
  always_comb begin
    w_next = r_state;
    w_rdata = {w_b0, w_b1, w_b2, w_b3};
    if (r_state == IDLE && enable) w_next = DONE;
    if (r_state == DONE && !enable) w_next = IDLE;
    if (data_length == 2'd0) w_rdata = {{(DATA_W-8){sig & w_b0[7]}}, w_b0};
    if (data_length == 2'd1) w_rdata = {{(DATA_W-16){sig & w_b0[7]}}, w_b0, w_b1};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && read_write) r_data <= w_rdata;
    end
  end
  // Storage is intentionally not reset; only the accepting edge writes it.
  always_ff @(posedge clk) begin
    if (w_accept && !read_write) begin
      if (data_length == 2'd0) memory[address] <= data_in[7:0];
      else if (data_length == 2'd1) begin
        memory[address] <= data_in[15:8];
        memory[w_a1]    <= data_in[7:0];
      end else begin
        memory[address] <= data_in[31:24];
        memory[w_a1]    <= data_in[23:16];
        memory[w_a2]    <= data_in[15:8];
        memory[w_a3]    <= data_in[7:0];
      end
    end
  end
  assign data_out = r_data;
  assign mfc = (r_state == DONE);
endmodule

// File: tb/tb_byte_ram.sv
// tb_byte_ram: directed self-checking bench for byte_ram.
module tb_byte_ram;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_out;
  logic        mfc;
  logic        enable = 1'b0;
  logic        read_write = 1'b1;
  logic        sig = 1'b0;
  logic [1:0]  data_length = 2'd0;
  logic [8:0]  address = '0;
  logic [31:0] data_in = '0;
  logic        mfc_pre, mfc_acc, mfc_rel;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  byte_ram dut (
    .clk(clk), .reset_n(reset_n), .data_out(data_out), .mfc(mfc),
    .enable(enable), .read_write(read_write), .sig(sig),
    .data_length(data_length), .address(address), .data_in(data_in)
  );

  always #5 clk = ~clk;

  // One request: drive, accept on next edge, then drop enable for one edge.
  task automatic access(input logic rw, input logic s, input logic [1:0] len,
                        input logic [8:0] a, input logic [31:0] d);
    read_write = rw; sig = s; data_length = len; address = a; data_in = d;
    enable = 1'b1;
    mfc_pre = mfc;
    @(posedge clk); #1;
    mfc_acc = mfc;
    enable = 1'b0;
    @(posedge clk); #1;
    mfc_rel = mfc;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    total_cnt++;
    if (data_out !== 32'h0) $display("FAIL reset_data_out got %h want %h", data_out, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (mfc !== 1'b0) $display("FAIL reset_mfc got %b want 0", mfc);
    else pass_cnt++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_read;
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 2'd0, 9'(i), 32'h0);
      total_cnt++;
      if (data_out !== 32'(i)) $display("FAIL byte_read[%0d] got %h want %h", i, data_out, 32'(i));
      else pass_cnt++;
      total_cnt++;
      if ({mfc_pre, mfc_acc, mfc_rel} !== 3'b010)
        $display("FAIL byte_read_mfc[%0d] got %b want 010", i, {mfc_pre, mfc_acc, mfc_rel});
      else pass_cnt++;
    end
  endtask

  task automatic test_sign_ext;
    access(1'b0, 1'b0, 2'd0, 9'd0, 32'h123456FF);
    total_cnt++;
    if (data_out !== 32'h0000000F) $display("FAIL write_holds_data_out got %h want %h", data_out, 32'h0000000F);
    else pass_cnt++;
    total_cnt++;
    if (dut.memory[1] !== 8'h01) $display("FAIL byte_write_neighbour got %h want %h", dut.memory[1], 8'h01);
    else pass_cnt++;
    access(1'b1, 1'b1, 2'd0, 9'd0, 32'h0);
    total_cnt++;
    if (data_out !== 32'hFFFFFFFF) $display("FAIL byte_sext got %h want %h", data_out, 32'hFFFFFFFF);
    else pass_cnt++;
    access(1'b1, 1'b0, 2'd0, 9'd0, 32'h0);
    total_cnt++;
    if (data_out !== 32'h000000FF) $display("FAIL byte_zext got %h want %h", data_out, 32'h000000FF);
    else pass_cnt++;
  endtask

  task automatic test_half;
    access(1'b0, 1'b0, 2'd1, 9'd2, 32'h9999FFFF);
    access(1'b0, 1'b0, 2'd1, 9'd4, 32'h00000800);
    total_cnt++;
    if ({dut.memory[4], dut.memory[5]} !== 16'h0800)
      $display("FAIL half_mem got %h want %h", {dut.memory[4], dut.memory[5]}, 16'h0800);
    else pass_cnt++;
    access(1'b1, 1'b1, 2'd1, 9'd4, 32'h0);
    total_cnt++;
    if (data_out !== 32'h00000800) $display("FAIL half_sext_pos got %h want %h", data_out, 32'h00000800);
    else pass_cnt++;
    access(1'b1, 1'b1, 2'd1, 9'd2, 32'h0);
    total_cnt++;
    if (data_out !== 32'hFFFFFFFF) $display("FAIL half_sext_neg got %h want %h", data_out, 32'hFFFFFFFF);
    else pass_cnt++;
    access(1'b1, 1'b0, 2'd1, 9'd2, 32'h0);
    total_cnt++;
    if (data_out !== 32'h0000FFFF) $display("FAIL half_zext got %h want %h", data_out, 32'h0000FFFF);
    else pass_cnt++;
  endtask

  task automatic test_word;
    access(1'b0, 1'b1, 2'd2, 9'd8, 32'h00100000);
    total_cnt++;
    if ({dut.memory[8], dut.memory[9], dut.memory[10], dut.memory[11]} !== 32'h00100000)
      $display("FAIL word_mem got %h want %h",
               {dut.memory[8], dut.memory[9], dut.memory[10], dut.memory[11]}, 32'h00100000);
    else pass_cnt++;
    access(1'b1, 1'b1, 2'd2, 9'd8, 32'h0);
    total_cnt++;
    if (data_out !== 32'h00100000) $display("FAIL word_read got %h want %h", data_out, 32'h00100000);
    else pass_cnt++;
    access(1'b1, 1'b0, 2'd3, 9'd0, 32'h0);
    total_cnt++;
    if (data_out !== 32'hFF01FFFF) $display("FAIL len3_as_word got %h want %h", data_out, 32'hFF01FFFF);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    access(1'b0, 1'b0, 2'd2, 9'd510, 32'hAABBCCDD);
    total_cnt++;
    if ({dut.memory[510], dut.memory[511], dut.memory[0], dut.memory[1]} !== 32'hAABBCCDD)
      $display("FAIL wrap_mem got %h want %h",
               {dut.memory[510], dut.memory[511], dut.memory[0], dut.memory[1]}, 32'hAABBCCDD);
    else pass_cnt++;
    access(1'b1, 1'b0, 2'd2, 9'd510, 32'h0);
    total_cnt++;
    if (data_out !== 32'hAABBCCDD) $display("FAIL wrap_word_read got %h want %h", data_out, 32'hAABBCCDD);
    else pass_cnt++;
    access(1'b1, 1'b1, 2'd1, 9'd511, 32'h0);
    total_cnt++;
    if (data_out !== 32'hFFFFBBCC) $display("FAIL wrap_half_read got %h want %h", data_out, 32'hFFFFBBCC);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    read_write = 1'b0; sig = 1'b0; data_length = 2'd0; address = 9'd20; data_in = 32'h11;
    enable = 1'b1;
    @(posedge clk); #1;
    address = 9'd21; data_in = 32'h22;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mfc !== 1'b1) $display("FAIL hold_mfc[%0d] got %b want 1", i, mfc);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    enable = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (mfc !== 1'b0) $display("FAIL hold_release_mfc got %b want 0", mfc);
    else pass_cnt++;
    total_cnt++;
    if ({dut.memory[20], dut.memory[21]} !== 16'h115A)
      $display("FAIL hold_single_op got %h want %h", {dut.memory[20], dut.memory[21]}, 16'h115A);
    else pass_cnt++;
    access(1'b1, 1'b0, 2'd0, 9'd20, 32'h0);
    total_cnt++;
    if (data_out !== 32'h00000011) $display("FAIL hold_readback got %h want %h", data_out, 32'h00000011);
    else pass_cnt++;
  endtask

  task automatic test_reset_done;
    read_write = 1'b0; data_length = 2'd2; address = 9'd12; data_in = 32'hDEADBEEF;
    enable = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({mfc, data_out} !== {1'b1, 32'h00000011})
      $display("FAIL done_before_reset got %b/%h want 1/%h", mfc, data_out, 32'h00000011);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (mfc !== 1'b0) $display("FAIL async_reset_mfc got %b want 0", mfc);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 32'h0) $display("FAIL async_reset_data_out got %h want %h", data_out, 32'h0);
    else pass_cnt++;
    enable = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({dut.memory[12], dut.memory[13], dut.memory[14], dut.memory[15]} !== 32'hDEADBEEF)
      $display("FAIL reset_keeps_write got %h want %h",
               {dut.memory[12], dut.memory[13], dut.memory[14], dut.memory[15]}, 32'hDEADBEEF);
    else pass_cnt++;
    access(1'b1, 1'b0, 2'd1, 9'd13, 32'h0);
    total_cnt++;
    if ({mfc_acc, data_out} !== {1'b1, 32'h0000ADBE})
      $display("FAIL after_reset_access got %b/%h want 1/%h", mfc_acc, data_out, 32'h0000ADBE);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dut.memory[i] = 8'(i);
    dut.memory[20] = 8'h00;
    dut.memory[21] = 8'h5A;
    test_reset;
    test_byte_read;
    test_sign_ext;
    test_half;
    test_word;
    test_wrap;
    test_hold;
    test_reset_done;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
